// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-detection inputs and stall/flush/perf outputs of the hazard controller; master = pipeline side, slave = controller
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic id_uses_rt;
  logic ex_MemRead;
  logic [4:0] ex_rt;
  logic branch_taken;
  logic mem_req;
  logic mem_ready;
  logic pc_write;
  logic if_id_write;
  logic id_ex_write;
  logic ex_mem_write;
  logic mem_wb_write;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt, branch_taken, mem_req, mem_ready,
    input pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
    input if_id_flush, id_ex_flush, ex_mem_flush, mem_timeout, stall_cycles, flush_count
  );
  modport slave (
    input id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt, branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
    output if_id_flush, id_ex_flush, ex_mem_flush, mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage stall/flush sequencer (load-use, branch squash, memory wait with timeout) with saturating perf counters; ports clk, rst, hz (slave)
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int WW = $clog2(MEM_TIMEOUT);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  state_t state, state_nx;
  logic [WW-1:0] wcnt, wcnt_nx;
  logic timeout_q, timeout_nx;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic freeze, load_use, br_flush;
  logic [7:0] ctrl;
  assign freeze = (state == RUN && hz.mem_req && !hz.mem_ready) ||
                  (state == MEM_WAIT && !hz.mem_ready) || state == ERR;
  assign load_use = hz.ex_MemRead && hz.ex_rt != 5'd0 &&
                    (hz.ex_rt == hz.id_rs || (hz.id_uses_rt && hz.ex_rt == hz.id_rt));
  assign br_flush = !freeze && hz.branch_taken;
  // {pc, if_id, id_ex, ex_mem, mem_wb writes, if_id, id_ex, ex_mem flushes}
  assign ctrl = rst      ? 8'hFF :
                freeze   ? 8'h00 :
                br_flush ? 8'hFF :
                load_use ? 8'h3A : 8'hF8;
  assign {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write, hz.mem_wb_write,
          hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush} = ctrl;
  assign hz.mem_timeout = timeout_q;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_count = flush_q;
  always_comb begin
    state_nx = state;
    wcnt_nx = wcnt;
    timeout_nx = timeout_q;
    if (state == RUN && hz.mem_req && !hz.mem_ready) begin
      state_nx = MEM_WAIT;
      wcnt_nx = WW'(1);
    end else if (state == MEM_WAIT) begin
      state_nx = hz.mem_ready ? RUN : (wcnt == WW'(MEM_TIMEOUT - 1)) ? ERR : MEM_WAIT;
      wcnt_nx = hz.mem_ready ? '0 : wcnt + 1'b1;
      timeout_nx = !hz.mem_ready && wcnt == WW'(MEM_TIMEOUT - 1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wcnt <= '0;
      timeout_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state <= state_nx;
      wcnt <= wcnt_nx;
      timeout_q <= timeout_nx;
      if (!hz.pc_write && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (br_flush && !(&flush_q)) flush_q <= flush_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for pipeline_hazard_ctrl, two instances (wide and 2-bit counters) on shared stimulus
module tb_pipeline_hazard_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  pipeline_hazard_ctrl_if #(.CNT_W(8)) if_a ();
  pipeline_hazard_ctrl_if #(.CNT_W(2)) if_b ();
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .hz(if_a.slave));
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .hz(if_b.slave));
  assign if_b.id_rs = if_a.id_rs;
  assign if_b.id_rt = if_a.id_rt;
  assign if_b.id_uses_rt = if_a.id_uses_rt;
  assign if_b.ex_MemRead = if_a.ex_MemRead;
  assign if_b.ex_rt = if_a.ex_rt;
  assign if_b.branch_taken = if_a.branch_taken;
  assign if_b.mem_req = if_a.mem_req;
  assign if_b.mem_ready = if_a.mem_ready;
  always #5 clk = ~clk;
  wire [7:0] ctrl_a = {if_a.pc_write, if_a.if_id_write, if_a.id_ex_write, if_a.ex_mem_write,
                       if_a.mem_wb_write, if_a.if_id_flush, if_a.id_ex_flush, if_a.ex_mem_flush};
  wire [7:0] ctrl_b = {if_b.pc_write, if_b.if_id_write, if_b.id_ex_write, if_b.ex_mem_write,
                       if_b.mem_wb_write, if_b.if_id_flush, if_b.id_ex_flush, if_b.ex_mem_flush};
  typedef struct {
    logic [7:0] ctrl;
    bit regs_ok;
    logic to;
    int sa, fa, sb, fb;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int ms = 0, mw = 0, msa = 0, mfa = 0, msb = 0, mfb = 0;
  bit mto = 0, mok = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      check("ctrl_a", 32'(ctrl_a), 32'(e.ctrl));
      check("ctrl_b", 32'(ctrl_b), 32'(e.ctrl));
      if (e.regs_ok) begin
        check("timeout_a", 32'(if_a.mem_timeout), 32'(e.to));
        check("timeout_b", 32'(if_b.mem_timeout), 32'(e.to));
        check("stall_a", 32'(if_a.stall_cycles), e.sa);
        check("flush_a", 32'(if_a.flush_count), e.fa);
        check("stall_b", 32'(if_b.stall_cycles), e.sb);
        check("flush_b", 32'(if_b.flush_count), e.fb);
      end
    end
  end
  // drive one cycle of stimulus, predict the outputs for it, then advance the model across the edge
  task automatic step(input bit r, input int rs, input int rt, input bit ut, input bit mr,
                      input int ert, input bit br, input bit req, input bit rdy);
    exp_t x;
    bit frz, lu;
    @(posedge clk);
    #1;
    rst = r;
    if_a.id_rs = 5'(rs);
    if_a.id_rt = 5'(rt);
    if_a.id_uses_rt = ut;
    if_a.ex_MemRead = mr;
    if_a.ex_rt = 5'(ert);
    if_a.branch_taken = br;
    if_a.mem_req = req;
    if_a.mem_ready = rdy;
    frz = (ms == 2) || (ms == 1 && !rdy) || (ms == 0 && req && !rdy);
    lu = mr && ert != 0 && (ert == rs || (ut && ert == rt));
    if (r) x.ctrl = 8'b11111_111;
    else if (frz) x.ctrl = 8'b00000_000;
    else if (br) x.ctrl = 8'b11111_111;
    else if (lu) x.ctrl = 8'b00111_010;
    else x.ctrl = 8'b11111_000;
    x.regs_ok = mok;
    x.to = mto;
    x.sa = msa;
    x.fa = mfa;
    x.sb = msb;
    x.fb = mfb;
    q.push_back(x);
    if (r) begin
      ms = 0; mw = 0; mto = 0; msa = 0; mfa = 0; msb = 0; mfb = 0; mok = 1;
    end else begin
      if (frz || lu && !br) begin
        if (msa < 255) msa++;
        if (msb < 3) msb++;
      end
      if (!frz && br) begin
        if (mfa < 255) mfa++;
        if (mfb < 3) mfb++;
      end
      if (ms == 0) begin
        if (req && !rdy) begin ms = 1; mw = 1; end
      end else if (ms == 1) begin
        if (rdy) begin ms = 0; mw = 0; end
        else if (mw == TO - 1) begin ms = 2; mto = 1; end
        else mw++;
      end
    end
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 1, 2, 1, 0, 0, 0, 0, 0);
  endtask
  initial begin
    if_a.id_rs = '0; if_a.id_rt = '0; if_a.id_uses_rt = 0; if_a.ex_MemRead = 0;
    if_a.ex_rt = '0; if_a.branch_taken = 0; if_a.mem_req = 0; if_a.mem_ready = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 5, 1, 1, 5, 1, 1, 0);
    idle(1);
    @(negedge clk);
    check("reset_stall", 32'(if_a.stall_cycles), 0);
    check("reset_to", 32'(if_a.mem_timeout), 0);
    idle(1);
    step(0, 5, 0, 0, 1, 5, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 3, 5, 0, 1, 5, 0, 0, 0);
    step(0, 3, 5, 1, 1, 5, 0, 0, 0);
    idle(1);
    step(0, 7, 2, 0, 1, 7, 1, 0, 0);
    idle(1);
    repeat (3) step(0, 1, 2, 0, 0, 0, 0, 1, 0);
    step(0, 1, 2, 0, 0, 0, 0, 1, 1);
    idle(1);
    repeat (2) step(0, 1, 2, 0, 0, 0, 1, 1, 0);
    step(0, 1, 2, 0, 0, 0, 1, 1, 1);
    idle(1);
    step(0, 1, 2, 0, 0, 0, 0, 1, 1);
    step(0, 1, 2, 0, 0, 0, 0, 0, 1);
    idle(1);
    repeat (6) step(0, 4, 4, 1, 1, 4, 1, 1, 0);
    @(negedge clk);
    check("timeout_set", 32'(if_a.mem_timeout), 1);
    check("err_freeze", 32'(ctrl_a), 0);
    step(1, 1, 2, 0, 0, 0, 0, 1, 0);
    idle(1);
    @(negedge clk);
    check("timeout_clr", 32'(if_a.mem_timeout), 0);
    repeat (5) begin
      step(0, 9, 0, 0, 1, 9, 0, 0, 0);
      idle(1);
    end
    @(negedge clk);
    check("sat_b", 32'(if_b.stall_cycles), 3);
    check("nosat_a", 32'(if_a.stall_cycles), 5);
    step(0, 9, 0, 0, 1, 9, 0, 0, 0);
    step(1, 9, 0, 0, 1, 9, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 24) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
           $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0);
    end
    idle(2);
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the write-enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazard classes:
- load-use hazards (ID/EX load feeding the instruction in ID);
- taken-branch squashes (branch resolved in MEM);
- multi-cycle data-memory waits (req/ready handshake), with timeout detection.

It also keeps saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before timeout error (>=2)
CNT_W, 16, width of performance counters

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
id_rs  input  5  rs field of instruction in IF/ID
id_rt  input  5  rt field of instruction in IF/ID
id_uses_rt  input  1  instruction in ID reads rt as a source
ex_MemRead  input  1  MemRead of instruction in ID/EX
ex_rt  input  5  instr_bits_20_16 of instruction in ID/EX
branch_taken  input  1  branch in MEM stage resolved taken
mem_req  input  1  MEM-stage access in progress (load or store)
mem_ready  input  1  data memory completes access this cycle
pc_write  output  1  PC load enable
if_id_write  output  1  IF/ID load enable
id_ex_write  output  1  ID/EX load enable
ex_mem_write  output  1  EX/MEM load enable
mem_wb_write  output  1  MEM/WB load enable
if_id_flush  output  1  IF/ID loads NOP on next edge
id_ex_flush  output  1  ID/EX loads bubble (all control bits 0)
ex_mem_flush  output  1  EX/MEM loads bubble
mem_timeout  output  1  sticky error: memory never became ready
stall_cycles  output  CNT_W  count of cycles with pc_write=0
flush_count  output  CNT_W  count of branch-flush cycles

Behaviour:
- State register: RUN, MEM_WAIT, ERR. Wait counter wcnt, width clog2(MEM_TIMEOUT).
- Control outputs are combinational from state and inputs. Counters and mem_timeout are registered.
- Reset (rst=1):
  - next state RUN, wcnt=0, mem_timeout=0, both counters 0;
  - while rst=1: all *_write=1 and all *_flush=1, so every pipeline register clears to bubble.
- Condition freeze = (state==RUN && mem_req && !mem_ready) || (state==MEM_WAIT && !mem_ready) || state==ERR.
- Priority: freeze > branch flush > load-use stall > normal.
- freeze:
  - all five *_write=0, all *_flush=0;
  - the WB instruction re-commits each frozen cycle, which is idempotent.
- Branch flush (not frozen, branch_taken=1):
  - all *_write=1;
  - if_id_flush=id_ex_flush=ex_mem_flush=1;
  - any load-use hazard is ignored because the instruction is squashed.
- Load-use condition: ex_MemRead && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
  - Response: pc_write=0, if_id_write=0, id_ex_flush=1; remaining writes 1.
  - Exactly one stall cycle per hazard; the condition clears after the bubble enters ID/EX.
- Normal: all *_write=1, all *_flush=0.
- Transitions:
  - RUN -> MEM_WAIT when mem_req && !mem_ready; wcnt<=1.
  - MEM_WAIT, mem_ready=1 -> RUN; freeze deasserted that same cycle, so the pipeline advances on that edge; wcnt<=0.
  - MEM_WAIT, !mem_ready, wcnt==MEM_TIMEOUT-1 -> ERR; mem_timeout<=1.
  - MEM_WAIT, otherwise: wcnt<=wcnt+1.
  - ERR holds until rst; freeze held, mem_timeout held at 1.
  - mem_ready with mem_req=0 in RUN is ignored.
- Single-cycle memory (mem_req && mem_ready in RUN): no freeze, no state change.
- branch_taken asserted during freeze: no flush while frozen. EX/MEM is held, so branch_taken persists and the flush applies on the first unfrozen cycle.
- stall_cycles increments on every non-reset cycle with pc_write=0, including ERR. It saturates at 2^CNT_W-1.
- flush_count increments on every branch-flush cycle and saturates the same way.
- rst mid-MEM_WAIT or in ERR: next cycle state RUN, mem_timeout 0.

Test Plan:
- Load-use: ex_MemRead=1, ex_rt=5, id_rs=5 -> for 1 cycle pc_write=0, if_id_write=0, id_ex_flush=1. With ex_rt=0 -> no stall. With id_rt=5, id_uses_rt=0 -> no stall.
- Branch vs load-use: branch_taken=1 and load-use hazard in the same cycle -> all writes 1, three flushes 1, stall_cycles unchanged, flush_count +1.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> all writes 0 for 3 cycles, then writes 1 in the ready cycle, state back to RUN, stall_cycles +3.
- Timeout with MEM_TIMEOUT=4: mem_req=1, mem_ready=0 held -> mem_timeout=1 after 4 cycles, freeze persists. Pulse rst -> mem_timeout=0, state RUN.
- Branch during freeze: branch_taken=1 while MEM_WAIT -> no flush until mem_ready=1, then flushes asserted that cycle, flush_count +1.
- Saturation with CNT_W=2: 5 load-use stalls -> stall_cycles=3. Reset mid-stall -> counters 0 and all writes/flushes 1 while rst=1.
